// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel
// plus a separate response channel.
//
// Handshake: a request transfers on a rising clk edge where imem_req_valid
// and imem_req_ready are both 1. The fetch side does not drop imem_req_valid
// while waiting for ready (only the address may change, on a redirect). The
// memory returns exactly one imem_rsp_valid pulse per accepted request, no
// earlier than the cycle after acceptance, and the response cannot be
// back-pressured.
interface if_stage_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_stage.sv
// RV32 fetch stage: owns the PC, issues one instruction fetch at a time,
// discards wrong-path responses after a redirect and fills IF/ID, with a
// one-entry skid buffer for a response that lands while IF/ID is stalled.
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCSel,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            stall,
    if_stage_if.master      imem,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_inst,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0]     ifid_inst_q, ifid_inst_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            handshake;
    logic            load_ok;
    logic            ld_en;
    logic [XLEN-1:0] ld_pc;
    logic [31:0]     ld_inst;

    // PCSel 11 is reserved and behaves as sequential fetch; JALR clears bit 0.
    assign redirect  = redirect_valid && (PCSel == 2'b01 || PCSel == 2'b10);
    assign target    = (PCSel == 2'b10) ? (alu_result & ~{{(XLEN-1){1'b0}}, 1'b1})
                                        : branch_target;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign handshake = imem.imem_req_valid && imem.imem_req_ready;
    assign load_ok   = !stall || !ifid_valid_q;

    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_addr      = pc_q;
    assign if_id_valid         = ifid_valid_q;
    assign if_id_pc            = ifid_pc_q;
    assign if_id_pc4           = ifid_pc4_q;
    assign if_id_inst          = ifid_inst_q;
    assign dbg_state           = state_q;

    // Fetch FSM: next state, next PC, skid buffer and IF/ID load request.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        ld_en        = 1'b0;
        ld_pc        = pc_q;
        ld_inst      = imem.imem_rsp_data;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) pc_d = target;
            end
            S_REQ: begin
                // Unaccepted request simply retargets; an accepted one is now stale.
                if (redirect) begin
                    pc_d    = target;
                    state_d = handshake ? S_DROP : S_REQ;
                end else if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem.imem_rsp_valid) begin
                    if (load_ok) begin
                        ld_en   = 1'b1;
                        ld_pc   = pc_q;
                        ld_inst = imem.imem_rsp_data;
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_inst_d  = imem.imem_rsp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    skid_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = S_REQ;
                end else if (load_ok) begin
                    ld_en        = 1'b1;
                    ld_pc        = skid_pc_q;
                    ld_inst      = skid_inst_q;
                    skid_valid_d = 1'b0;
                    pc_d         = pc_plus4;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                // Keep tracking redirects until the stale response drains.
                if (redirect) pc_d = target;
                if (imem.imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IF/ID register: flush beats load beats stall-hold beats bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_inst_d  = ifid_inst_q;
        if (redirect) begin
            ifid_valid_d = 1'b0;
        end else if (ld_en) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = ld_pc;
            ifid_pc4_d   = ld_pc + XLEN'(4);
            ifid_inst_d  = ld_inst;
        end else if (!stall) begin
            ifid_valid_d = 1'b0;
        end
    end

    // State, PC, skid buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_inst_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_inst_q  <= ifid_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a memory responder plus an instruction-stream model
// (expected next PC, expected IF/ID contents, pending-fetch bookkeeping).
module tb_if_stage;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  PCSel;
    logic        redirect_valid;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic [2:0]  dbg_state;

    if_stage_if #(.XLEN(XLEN)) imem ();

    if_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCSel          (PCSel),
        .redirect_valid (redirect_valid),
        .branch_target  (branch_target),
        .alu_result     (alu_result),
        .stall          (stall),
        .imem           (imem),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_inst     (if_id_inst),
        .dbg_state      (dbg_state)
    );

    // Scoreboard counters
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: word at address a.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h0000_000A;
    endfunction

    // Instruction-stream model
    logic [31:0] exp_pc;        // PC of the next instruction the stage must deliver
    logic        m_valid;       // expected if_id_valid
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_skid;        // a good response is parked, waiting for IF/ID
    // Memory bookkeeping
    logic        pend_valid;    // accepted request not yet answered
    logic [31:0] pend_addr;
    logic        pend_wrong;    // that request was overtaken by a redirect
    int          pend_cnt;
    int          lat_lo = 0;
    int          lat_hi = 0;
    logic        prev_req;
    logic [31:0] prev_addr;
    int          loads = 0;
    logic [7:0]  seen_states = '0;

    // One clock: apply the edge to the model, compare, then drive the memory.
    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        logic        hs;
        logic        rsp_now;
        logic        wrong_now;
        logic        avail;
        logic        exp_req;
        @(posedge clk);
        #1;
        redir = redirect_valid && (PCSel == 2'd1 || PCSel == 2'd2);
        tgt   = (PCSel == 2'd2) ? {alu_result[31:1], 1'b0} : branch_target;
        hs    = prev_req && imem.imem_req_ready;
        if (!rst_n) begin
            exp_pc     = RESET_PC;
            m_valid    = 1'b0;
            m_skid     = 1'b0;
            pend_valid = 1'b0;
            pend_wrong = 1'b0;
            exp_req    = 1'b0;
            check_eq("rst_pc", if_id_pc, 32'h0);
            check_eq("rst_pc4", if_id_pc4, 32'h0);
            check_eq("rst_inst", if_id_inst, 32'h0);
        end else begin
            if (hs) check_eq("one_outstanding", {31'b0, pend_valid}, 32'h0);
            if (prev_req && !imem.imem_req_ready && !redir)
                check_eq("addr_stable", imem.imem_addr, prev_addr);
            rsp_now   = imem.imem_rsp_valid;
            wrong_now = pend_wrong;
            if (rsp_now) pend_valid = 1'b0;
            if (hs) begin
                pend_valid = 1'b1;
                pend_addr  = prev_addr;
                pend_wrong = redir;
                pend_cnt   = $urandom_range(lat_hi, lat_lo);
            end
            if (redir && pend_valid) pend_wrong = 1'b1;
            if (redir) begin
                m_valid = 1'b0;
                m_skid  = 1'b0;
                exp_pc  = tgt;
            end else begin
                avail = (rsp_now && !wrong_now) || m_skid;
                if (avail && (!stall || !m_valid)) begin
                    m_valid = 1'b1;
                    m_pc    = exp_pc;
                    m_inst  = mem_word(exp_pc);
                    exp_pc  = exp_pc + 32'd4;
                    m_skid  = 1'b0;
                    loads++;
                end else if (avail) begin
                    m_skid = 1'b1;
                end else if (!(stall && m_valid)) begin
                    m_valid = 1'b0;
                end
            end
            exp_req = !pend_valid && !m_skid;
        end
        check_eq("req_valid", {31'b0, imem.imem_req_valid}, {31'b0, exp_req});
        check_eq("imem_addr", imem.imem_addr, exp_pc);
        check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check_eq("if_id_pc", if_id_pc, m_pc);
            check_eq("if_id_pc4", if_id_pc4, m_pc + 32'd4);
            check_eq("if_id_inst", if_id_inst, m_inst);
        end
        seen_states[dbg_state] = 1'b1;
        prev_req  = imem.imem_req_valid;
        prev_addr = imem.imem_addr;
        // Memory responder
        if (pend_valid && pend_cnt == 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(pend_addr);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
            if (pend_valid) pend_cnt--;
        end
    endtask

    // Driver: random cycle inputs
    task automatic rand_inputs();
        rst_n               = ($urandom_range(0, 499) != 0);
        imem.imem_req_ready = ($urandom_range(0, 3) != 0);
        stall               = ($urandom_range(0, 3) == 0);
        redirect_valid      = ($urandom_range(0, 9) == 0);
        PCSel               = 2'($urandom_range(0, 3));
        branch_target       = $urandom;
        alu_result          = $urandom;
    endtask

    initial begin
        int i;
        rst_n               = 1'b0;
        PCSel               = 2'd0;
        redirect_valid      = 1'b0;
        branch_target       = '0;
        alu_result          = '0;
        stall               = 1'b0;
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        prev_req   = 1'b0;
        prev_addr  = '0;
        exp_pc     = RESET_PC;
        m_valid    = 1'b0;
        m_pc       = '0;
        m_inst     = '0;
        m_skid     = 1'b0;
        pend_valid = 1'b0;
        pend_addr  = '0;
        pend_wrong = 1'b0;
        pend_cnt   = 0;

        // Reset, then sequential fetch of 0x0, 0x4, 0x8 with a 1-cycle memory.
        step();
        step();
        check_eq("rst_req_low", {31'b0, imem.imem_req_valid}, 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("first_req", {31'b0, imem.imem_req_valid}, 32'h1);
        for (i = 0; i < 30 && !(pend_valid && pend_addr == 32'h8); i++) step();
        check_eq("reach_wait_0x8", {31'b0, pend_valid && pend_addr == 32'h8}, 32'h1);
        check_eq("stream_pc_0x4", if_id_pc, 32'h4);
        check_eq("stream_inst_0xB", if_id_inst, 32'hB);

        // Branch redirect while waiting on 0x8.
        redirect_valid = 1'b1;
        PCSel          = 2'b01;
        branch_target  = 32'h100;
        step();
        check_eq("br_flush", {31'b0, if_id_valid}, 32'h0);
        check_eq("br_addr", imem.imem_addr, 32'h100);

        // JALR clears bit 0; reserved PCSel keeps sequential fetch.
        PCSel      = 2'b10;
        alu_result = 32'h203;
        step();
        check_eq("jalr_addr", imem.imem_addr, 32'h202);
        PCSel         = 2'b11;
        branch_target = 32'h500;
        repeat (6) step();
        redirect_valid = 1'b0;
        PCSel          = 2'b00;

        // Stall while a response arrives: park it, issue nothing, then release.
        stall = 1'b1;
        for (i = 0; i < 30 && !m_skid; i++) step();
        check_eq("reach_hold", {31'b0, m_skid}, 32'h1);
        repeat (3) begin
            step();
            check_eq("hold_no_req", {31'b0, imem.imem_req_valid}, 32'h0);
        end
        stall = 1'b0;
        step();
        check_eq("hold_release", {31'b0, if_id_valid}, 32'h1);

        // Back-pressure: three cycles of ready=0, accepted on the fourth.
        for (i = 0; i < 30 && !imem.imem_req_valid; i++) step();
        imem.imem_req_ready = 1'b0;
        repeat (3) begin
            step();
            check_eq("bp_req_held", {31'b0, imem.imem_req_valid}, 32'h1);
        end
        imem.imem_req_ready = 1'b1;
        step();
        check_eq("bp_accepted", {31'b0, pend_valid}, 32'h1);

        // Redirect and stall together with IF/ID valid: flush wins.
        for (i = 0; i < 30 && !if_id_valid; i++) step();
        check_eq("reach_valid", {31'b0, if_id_valid}, 32'h1);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        PCSel          = 2'b01;
        branch_target  = 32'h300;
        step();
        check_eq("flush_over_stall", {31'b0, if_id_valid}, 32'h0);
        check_eq("flush_addr", imem.imem_addr, 32'h300);
        stall          = 1'b0;
        redirect_valid = 1'b0;

        // Reset while a fetch is outstanding.
        lat_lo = 2;
        lat_hi = 2;
        for (i = 0; i < 30 && !pend_valid; i++) step();
        check_eq("reach_wait", {31'b0, pend_valid}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_addr", imem.imem_addr, RESET_PC);

        // Random traffic with variable memory latency.
        lat_lo = 0;
        lat_hi = 3;
        repeat (3000) begin
            rand_inputs();
            step();
        end
        check_eq("progress", {31'b0, loads >= 200}, 32'h1);

        $display("states visited: %0d", $countones(seen_states));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the RV32 pipeline; directly consumes the 2-bit PCSel produced by the PC-select logic.
- Owns the PC register and computes the next PC.
- Issues one outstanding instruction-memory request at a time over a valid/ready request channel with a separate response channel.
- Drops wrong-path responses after a redirect and drives the IF/ID pipeline register, honouring stall (hold) and flush.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
PCSel  input  2  00: PC+4, 01: branch_target, 10: alu_result, 11: reserved (treated as 00)
redirect_valid  input  1  EX-stage instruction is valid; qualifies PCSel
branch_target  input  XLEN  PC+imm from EX
alu_result  input  XLEN  JALR target from EX
stall  input  1  hazard unit: hold IF/ID
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  request address
imem_rsp_valid  input  1  response valid, one per accepted request, ≥1 cycle after acceptance
imem_rsp_data  input  32  instruction word
if_id_valid  output  1  IF/ID holds a valid instruction
if_id_pc  output  XLEN  PC of IF/ID instruction
if_id_pc4  output  XLEN  if_id_pc + 4
if_id_inst  output  32  instruction

Behaviour:
- Redirect:
  - redirect = redirect_valid && (PCSel==01 || PCSel==10).
  - Target = branch_target for 01; {alu_result[XLEN-1:1],1'b0} for 10.
  - PCSel==11 never redirects.
  - All PC arithmetic wraps modulo 2^XLEN; no alignment check beyond the JALR bit-0 clear.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- Reset (rst_n low at a clock edge):
  - State = IDLE, pc = RESET_PC.
  - if_id_valid, if_id_pc, if_id_pc4 and if_id_inst all = 0.
  - Skid buffer invalid.
- Combinational outputs:
  - imem_req_valid = (state==REQ); reads 0 during and right after reset.
  - imem_addr = pc always.
- IDLE: always -> REQ next cycle.
- REQ:
  - On handshake (imem_req_valid && imem_req_ready): -> WAIT.
  - Redirect without handshake: pc <= target, stay in REQ. The address may change because the request was never accepted.
  - Redirect with handshake: pc <= target, -> DROP.
- WAIT, on imem_rsp_valid without redirect:
  - Load condition: (!stall || !if_id_valid). If it holds: IF/ID <= {1, pc, pc+4, data}, pc <= pc+4, -> REQ.
  - Otherwise capture {pc, data} in the skid buffer, -> HOLD.
- WAIT, on redirect (with or without response): pc <= target, -> DROP if no response arrived this cycle, else -> REQ. The response is discarded.
- HOLD:
  - No request issued.
  - When the load condition holds: IF/ID <= skid contents, pc <= pc+4, -> REQ.
  - Redirect: discard skid, pc <= target, -> REQ.
- DROP:
  - Wait for imem_rsp_valid and discard it, -> REQ.
  - Redirect in DROP: pc <= target, stay until the stale response arrives.
- IF/ID update priority: redirect (flush: if_id_valid <= 0, other fields don't-care) > load > stall (hold all fields) > bubble (if_id_valid <= 0 when nothing loads and not stalled).
- Redirect and stall in the same cycle: the flush wins.
- Latency:
  - With ready=1 and a 1-cycle response, one instruction every 2 cycles.
  - First imem_req_valid occurs 1 cycle after rst_n rises.
- At most one request outstanding. The skid buffer holds at most one entry. No request is issued in HOLD or DROP.
- imem_req_valid is never withdrawn while ready=0, except on a redirect. On a redirect imem_req_valid stays 1 and only the address changes.

Test Plan:
- Reset, RESET_PC=0, ready=1, response 1 cycle after acceptance, insts 0xA,0xB,0xC -> imem_addr 0x0,0x4,0x8. IF/ID shows pc 0x0/inst 0xA, then 0x4/0xB, then 0x8/0xC, with pc4 = pc+4.
- During WAIT for 0x8: redirect_valid=1, PCSel=01, branch_target=0x100 -> the 0x8 response is dropped, if_id_valid=0 next cycle, next imem_addr = 0x100.
- PCSel=10, alu_result=0x203 -> next request address 0x202. PCSel=11 with redirect_valid=1 -> sequential PC continues.
- if_id_valid=1, stall=1 when the response for 0x10 arrives -> HOLD, no request, IF/ID unchanged. Stall released -> IF/ID = pc 0x10, next imem_addr 0x14.
- imem_req_ready=0 for 3 cycles in REQ -> imem_req_valid=1 and imem_addr stable. Accepted on cycle 4.
- Redirect and stall in the same cycle with IF/ID valid -> if_id_valid=0 next cycle, pc = target. rst_n low during WAIT -> IDLE, pc=RESET_PC, if_id_valid=0.
